// File: rtl/vram_arbiter.sv
// Shares one memory command port between video line-buffer burst fetches and
// single-word host accesses; contention is resolved by alternating grants.
module vram_arbiter #(
    parameter int unsigned AW    = 22,
    parameter int unsigned DW    = 16,
    parameter int unsigned BURST = 16,
    parameter int unsigned LBW   = 10
) (
    input  logic           PixelClk2,
    input  logic           Reset,
    input  logic           VidReq,
    input  logic [AW-1:0]  VidAddr,
    input  logic [LBW-1:0] VidLbAddr,
    output logic           VidAck,
    output logic           VidDone,
    output logic           LbWe,
    output logic [LBW-1:0] LbAddr,
    output logic [DW-1:0]  LbData,
    input  logic           HostReq,
    input  logic           HostWe,
    input  logic [AW-1:0]  HostAddr,
    input  logic [DW-1:0]  HostWData,
    output logic [DW-1:0]  HostRData,
    output logic           HostAck,
    output logic           MemCmdValid,
    input  logic           MemCmdReady,
    output logic           MemWe,
    output logic [AW-1:0]  MemAddr,
    output logic [DW-1:0]  MemWData,
    input  logic           MemRValid,
    input  logic [DW-1:0]  MemRData,
    output logic           Busy,
    output logic           ErrStray
);

    localparam int unsigned CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] BurstLast = CW'(BURST - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVcmd,
        StVdata,
        StHcmd,
        StHdata
    } state_e;

    state_e         state;
    logic [CW-1:0]  cmd_cnt;
    logic [CW-1:0]  dat_cnt;
    logic [LBW-1:0] lbbase;
    logic           last_vid;

    logic cmd_fire;
    logic in_video;
    logic vid_beat;
    logic vid_last;
    logic stray;
    logic host_req;
    logic grant_vid;
    logic grant_host;

    always_comb begin
        cmd_fire = MemCmdValid && MemCmdReady;
        in_video = (state == StVcmd) || (state == StVdata);
        // A beat is only legal for a command that has already been accepted.
        vid_beat = in_video && MemRValid && (dat_cnt < cmd_cnt);
        vid_last = vid_beat && (dat_cnt == BurstLast);
        stray    = MemRValid && !vid_beat && (state != StHdata);
        // The host still holds its request during its ack cycle; do not re-grant it.
        host_req   = HostReq && !HostAck;
        grant_vid  = (state == StIdle) && VidReq && (!host_req || !last_vid);
        grant_host = (state == StIdle) && host_req && !grant_vid;
        VidAck  = grant_vid;
        VidDone = vid_last;
        LbWe    = vid_beat;
        LbAddr  = lbbase + LBW'(dat_cnt);
        LbData  = MemRData;
        Busy    = (state != StIdle);
    end

    always_ff @(posedge PixelClk2) begin
        if (Reset) begin
            state       <= StIdle;
            cmd_cnt     <= '0;
            dat_cnt     <= '0;
            lbbase      <= '0;
            last_vid    <= 1'b0;
            MemCmdValid <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            HostRData   <= '0;
            HostAck     <= 1'b0;
            ErrStray    <= 1'b0;
        end else begin
            HostAck <= 1'b0;
            if (stray) begin
                ErrStray <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (grant_vid) begin
                        last_vid    <= 1'b1;
                        lbbase      <= VidLbAddr;
                        cmd_cnt     <= '0;
                        dat_cnt     <= '0;
                        MemCmdValid <= 1'b1;
                        MemWe       <= 1'b0;
                        MemAddr     <= VidAddr;
                        state       <= StVcmd;
                    end else if (grant_host) begin
                        last_vid    <= 1'b0;
                        MemCmdValid <= 1'b1;
                        MemWe       <= HostWe;
                        MemAddr     <= HostAddr;
                        MemWData    <= HostWData;
                        state       <= StHcmd;
                    end
                end
                StVcmd, StVdata: begin
                    if (cmd_fire) begin
                        cmd_cnt <= cmd_cnt + CW'(1);
                        MemAddr <= MemAddr + AW'(1);
                        if (cmd_cnt == BurstLast) begin
                            MemCmdValid <= 1'b0;
                            state       <= StVdata;
                        end
                    end
                    if (vid_beat) begin
                        dat_cnt <= dat_cnt + CW'(1);
                    end
                    if (vid_last) begin
                        state <= StIdle;
                    end
                end
                StHcmd: begin
                    if (cmd_fire) begin
                        MemCmdValid <= 1'b0;
                        if (MemWe) begin
                            HostAck <= 1'b1;
                            state   <= StIdle;
                        end else begin
                            state <= StHdata;
                        end
                    end
                end
                StHdata: begin
                    if (MemRValid) begin
                        HostRData <= MemRData;
                        HostAck   <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a behavioural memory and
// a transaction-level model of grant order, command stream and line-buffer writes.
module tb_vram_arbiter;

    localparam int AW    = 22;
    localparam int DW    = 16;
    localparam int BURST = 16;
    localparam int LBW   = 10;

    logic           PixelClk2;
    logic           Reset;
    logic           VidReq;
    logic [AW-1:0]  VidAddr;
    logic [LBW-1:0] VidLbAddr;
    logic           VidAck;
    logic           VidDone;
    logic           LbWe;
    logic [LBW-1:0] LbAddr;
    logic [DW-1:0]  LbData;
    logic           HostReq;
    logic           HostWe;
    logic [AW-1:0]  HostAddr;
    logic [DW-1:0]  HostWData;
    logic [DW-1:0]  HostRData;
    logic           HostAck;
    logic           MemCmdValid;
    logic           MemCmdReady;
    logic           MemWe;
    logic [AW-1:0]  MemAddr;
    logic [DW-1:0]  MemWData;
    logic           MemRValid;
    logic [DW-1:0]  MemRData;
    logic           Busy;
    logic           ErrStray;

    vram_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .LBW(LBW)) dut (
        .PixelClk2   (PixelClk2),
        .Reset       (Reset),
        .VidReq      (VidReq),
        .VidAddr     (VidAddr),
        .VidLbAddr   (VidLbAddr),
        .VidAck      (VidAck),
        .VidDone     (VidDone),
        .LbWe        (LbWe),
        .LbAddr      (LbAddr),
        .LbData      (LbData),
        .HostReq     (HostReq),
        .HostWe      (HostWe),
        .HostAddr    (HostAddr),
        .HostWData   (HostWData),
        .HostRData   (HostRData),
        .HostAck     (HostAck),
        .MemCmdValid (MemCmdValid),
        .MemCmdReady (MemCmdReady),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRValid   (MemRValid),
        .MemRData    (MemRData),
        .Busy        (Busy),
        .ErrStray    (ErrStray)
    );

    initial begin
        PixelClk2 = 1'b0;
        forever #5 PixelClk2 = ~PixelClk2;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic [LBW-1:0] addr;
        logic [DW-1:0]  data;
        logic           last;
    } lb_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } resp_t;

    cmd_t          exp_cmd[$];
    lb_t           exp_lb[$];
    logic [DW-1:0] exp_host[$];
    bit            exp_event[$];   // 1 = video burst completes, 0 = host access completes

    logic [DW-1:0] ref_mem[bit [AW-1:0]];
    logic [DW-1:0] ram[bit [AW-1:0]];
    bit            model_last_vid;
    logic [DW-1:0] last_rdata;

    int n_cmp;
    int n_err;
    int n_acc;
    int n_lbwe;
    int n_done;
    int n_hack;
    int n_vcyc;

    int rdy_mode;
    int lat_fixed;
    bit hold_ready;
    bit inject_stray;

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return a[15:0] ^ {a[21:16], 10'h15A};
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return mem_init(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected by the model", name);
    endtask

    function automatic void predict_video(input logic [AW-1:0] va, input logic [LBW-1:0] la);
        logic [AW-1:0]  a;
        logic [LBW-1:0] l;
        for (int i = 0; i < BURST; i++) begin
            a = va + AW'(i);
            l = la + LBW'(i);
            exp_cmd.push_back('{we: 1'b0, addr: a, wdata: '0});
            exp_lb.push_back('{addr: l, data: ref_read(a), last: (i == BURST - 1)});
        end
        exp_event.push_back(1'b1);
    endfunction

    function automatic void predict_host(input logic hwe, input logic [AW-1:0] ha,
                                         input logic [DW-1:0] hd);
        exp_cmd.push_back('{we: hwe, addr: ha, wdata: hd});
        if (hwe) ref_mem[ha] = hd;
        else last_rdata = ref_read(ha);
        exp_host.push_back(last_rdata);
        exp_event.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        exp_cmd.delete();
        exp_lb.delete();
        exp_host.delete();
        exp_event.delete();
        model_last_vid = 1'b0;
        last_rdata     = '0;
    endfunction

    // Memory controller: in-order read responses after a per-command latency.
    initial begin
        resp_t         resp[$];
        resp_t         r;
        int unsigned   cyc;
        int unsigned   last_due;
        int unsigned   d;
        int            vrun;
        bit            acc;
        bit            a_rst;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wd;
        cyc = 0;
        last_due = 0;
        vrun = 0;
        MemCmdReady = 1'b0;
        MemRValid = 1'b0;
        MemRData = '0;
        forever begin
            @(negedge PixelClk2);
            acc    = MemCmdValid && MemCmdReady;
            a_we   = MemWe;
            a_addr = MemAddr;
            a_wd   = MemWData;
            a_rst  = Reset;
            if (MemCmdValid && !MemCmdReady) vrun++;
            else vrun = 0;
            @(posedge PixelClk2);
            #1;
            cyc++;
            if (a_rst) begin
                resp.delete();
                vrun = 0;
                last_due = 0;
            end else if (acc) begin
                if (a_we) begin
                    ram[a_addr] = a_wd;
                end else begin
                    d = cyc + ((lat_fixed > 0) ? lat_fixed : $urandom_range(1, 4)) - 1;
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    resp.push_back('{due: d, data: ram_read(a_addr)});
                end
            end
            MemRValid = 1'b0;
            MemRData  = DW'($urandom);
            if (inject_stray) begin
                MemRValid    = 1'b1;
                inject_stray = 1'b0;
            end else if (resp.size() > 0 && resp[0].due <= cyc) begin
                r = resp.pop_front();
                MemRValid = 1'b1;
                MemRData  = r.data;
            end
            if (hold_ready) MemCmdReady = 1'b0;
            else if (rdy_mode == 0) MemCmdReady = 1'b1;
            else if (rdy_mode == 1) MemCmdReady = ($urandom_range(0, 9) < 7);
            else MemCmdReady = (vrun >= 5);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        cmd_t          c;
        lb_t           l;
        logic [DW-1:0] h;
        bit            pend;
        logic          p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wd;
        pend = 1'b0;
        forever begin
            @(negedge PixelClk2);
            if (Reset) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("cmd_hold_valid", 32'(MemCmdValid), 32'(1));
                check("cmd_hold_addr", 32'(MemAddr), 32'(p_addr));
                check("cmd_hold_we", 32'(MemWe), 32'(p_we));
                if (p_we) check("cmd_hold_wdata", 32'(MemWData), 32'(p_wd));
            end
            pend   = MemCmdValid && !MemCmdReady;
            p_we   = MemWe;
            p_addr = MemAddr;
            p_wd   = MemWData;
            if (MemCmdValid) begin
                n_vcyc++;
                check("cmd_valid_busy", 32'(Busy), 32'(1));
            end
            if (MemCmdValid && MemCmdReady) begin
                n_acc++;
                if (exp_cmd.size() == 0) begin
                    fail_note("mem_cmd");
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_we", 32'(MemWe), 32'(c.we));
                    check("cmd_addr", 32'(MemAddr), 32'(c.addr));
                    if (c.we) check("cmd_wdata", 32'(MemWData), 32'(c.wdata));
                end
            end
            if (LbWe) begin
                n_lbwe++;
                if (exp_lb.size() == 0) begin
                    fail_note("lb_we");
                end else begin
                    l = exp_lb.pop_front();
                    check("lb_addr", 32'(LbAddr), 32'(l.addr));
                    check("lb_data", 32'(LbData), 32'(l.data));
                    check("vid_done_on_last", 32'(VidDone), 32'(l.last));
                end
            end else if (VidDone) begin
                fail_note("vid_done_without_lbwe");
            end
            if (VidDone) begin
                n_done++;
                if (exp_event.size() == 0) fail_note("vid_done");
                else check("order_video", 32'(exp_event.pop_front()), 32'(1));
            end
            if (HostAck) begin
                n_hack++;
                if (exp_event.size() == 0 || exp_host.size() == 0) begin
                    fail_note("host_ack");
                end else begin
                    check("order_host", 32'(exp_event.pop_front()), 32'(0));
                    h = exp_host.pop_front();
                    check("host_rdata", 32'(HostRData), 32'(h));
                end
            end
        end
    end

    task automatic run_round(input bit v, input bit h, input logic [AW-1:0] va,
                             input logic [LBW-1:0] la, input bit hwe,
                             input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        bit vfirst;
        bit vs;
        bit hs;
        bit fin;
        vfirst = v && (!h || !model_last_vid);
        if (vfirst) predict_video(va, la);
        if (h) predict_host(hwe, ha, hd);
        if (v && !vfirst) predict_video(va, la);
        if (v && h) model_last_vid = !vfirst;
        else if (v) model_last_vid = 1'b1;
        else if (h) model_last_vid = 1'b0;
        @(posedge PixelClk2);
        #1;
        VidReq = v;
        VidAddr = va;
        VidLbAddr = la;
        HostReq = h;
        HostWe = hwe;
        HostAddr = ha;
        HostWData = hd;
        vs = 1'b0;
        hs = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge PixelClk2);
            if (VidAck) vs = 1'b1;
            if (HostAck) hs = 1'b1;
            @(posedge PixelClk2);
            #1;
            if (vs) VidReq = 1'b0;
            if (hs) HostReq = 1'b0;
            fin = (!v || vs) && (!h || hs) && (exp_event.size() == 0) && !Busy;
        end
        if (!fin) begin
            fail_note("round_timeout");
            VidReq = 1'b0;
            HostReq = 1'b0;
            exp_cmd.delete();
            exp_lb.delete();
            exp_host.delete();
            exp_event.delete();
        end
    endtask

    initial begin
        int a0;
        int l0;
        int d0;
        int h0;
        int v0;
        int k;
        bit seen;
        bit rv;
        bit rh;
        n_cmp = 0;
        n_err = 0;
        n_acc = 0;
        n_lbwe = 0;
        n_done = 0;
        n_hack = 0;
        n_vcyc = 0;
        rdy_mode = 0;
        lat_fixed = 2;
        hold_ready = 1'b0;
        inject_stray = 1'b0;
        model_reset();
        Reset = 1'b1;
        VidReq = 1'b0;
        VidAddr = '0;
        VidLbAddr = '0;
        HostReq = 1'b0;
        HostWe = 1'b0;
        HostAddr = '0;
        HostWData = '0;
        repeat (3) @(posedge PixelClk2);
        @(negedge PixelClk2);
        check("rst_vid_ack", 32'(VidAck), 32'(0));
        check("rst_vid_done", 32'(VidDone), 32'(0));
        check("rst_lb_we", 32'(LbWe), 32'(0));
        check("rst_host_ack", 32'(HostAck), 32'(0));
        check("rst_cmd_valid", 32'(MemCmdValid), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_err_stray", 32'(ErrStray), 32'(0));
        check("rst_host_rdata", 32'(HostRData), 32'(0));
        @(posedge PixelClk2);
        #1;
        Reset = 1'b0;

        // First tie after reset goes to video, the next tie to video again after the host turn.
        run_round(1'b1, 1'b1, 22'h000100, 10'h020, 1'b1, 22'h001234, 16'h1111);
        run_round(1'b1, 1'b1, 22'h000200, 10'h100, 1'b0, 22'h001234, 16'h0000);

        a0 = n_acc;
        l0 = n_lbwe;
        d0 = n_done;
        run_round(1'b1, 1'b0, 22'h000100, 10'h020, 1'b0, '0, '0);
        check("burst_cmd_count", 32'(n_acc - a0), 32'(16));
        check("burst_lbwe_count", 32'(n_lbwe - l0), 32'(16));
        check("burst_done_count", 32'(n_done - d0), 32'(1));
        check("burst_no_stray", 32'(ErrStray), 32'(0));

        run_round(1'b1, 1'b0, 22'h3FFFF8, 10'h3F8, 1'b0, '0, '0);

        rdy_mode = 2;
        v0 = n_vcyc;
        l0 = n_lbwe;
        h0 = n_hack;
        run_round(1'b0, 1'b1, '0, '0, 1'b1, 22'h3FFFFF, 16'hBEEF);
        check("slow_ready_valid_cycles", 32'(n_vcyc - v0), 32'(6));
        check("slow_ready_host_acks", 32'(n_hack - h0), 32'(1));
        check("slow_ready_no_lbwe", 32'(n_lbwe - l0), 32'(0));
        rdy_mode = 0;
        run_round(1'b0, 1'b1, '0, '0, 1'b0, 22'h3FFFFF, '0);

        rdy_mode = 1;
        lat_fixed = 0;
        for (int i = 0; i < 30; i++) begin
            rv = 1'($urandom);
            rh = 1'($urandom);
            if (!rv && !rh) rh = 1'b1;
            run_round(rv, rh, AW'($urandom), LBW'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 22'h3FFFFF : AW'($urandom), DW'($urandom));
        end
        check("random_no_stray", 32'(ErrStray), 32'(0));

        // Reset in the middle of a burst, after the 7th command is accepted.
        rdy_mode = 0;
        lat_fixed = 2;
        predict_video(22'h012340, 10'h155);
        @(posedge PixelClk2);
        #1;
        VidReq = 1'b1;
        VidAddr = 22'h012340;
        VidLbAddr = 10'h155;
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && k < 7; c++) begin
            @(negedge PixelClk2);
            if (VidAck) seen = 1'b1;
            if (MemCmdValid && MemCmdReady) k++;
            if (k < 7) begin
                @(posedge PixelClk2);
                #1;
                if (seen) VidReq = 1'b0;
            end
        end
        check("midburst_accepts", 32'(k), 32'(7));
        hold_ready = 1'b1;
        @(posedge PixelClk2);
        #1;
        VidReq = 1'b0;
        Reset = 1'b1;
        @(posedge PixelClk2);
        #1;
        Reset = 1'b0;
        hold_ready = 1'b0;
        model_reset();
        d0 = n_done;
        @(negedge PixelClk2);
        check("midburst_busy", 32'(Busy), 32'(0));
        check("midburst_cmd_valid", 32'(MemCmdValid), 32'(0));
        check("midburst_lb_we", 32'(LbWe), 32'(0));
        check("midburst_vid_done", 32'(VidDone), 32'(0));
        check("midburst_host_ack", 32'(HostAck), 32'(0));
        repeat (30) @(negedge PixelClk2);
        check("midburst_no_done", 32'(n_done - d0), 32'(0));
        check("midburst_no_stray", 32'(ErrStray), 32'(0));
        run_round(1'b0, 1'b1, '0, '0, 1'b0, 22'h012345, '0);

        // Read data with nothing outstanding sets the sticky error.
        @(negedge PixelClk2);
        inject_stray = 1'b1;
        repeat (3) @(negedge PixelClk2);
        check("stray_set", 32'(ErrStray), 32'(1));
        run_round(1'b1, 1'b1, 22'h0ABCD0, 10'h0F0, 1'b1, 22'h000777, 16'h7777);
        check("stray_sticky", 32'(ErrStray), 32'(1));
        @(posedge PixelClk2);
        #1;
        Reset = 1'b1;
        @(posedge PixelClk2);
        #1;
        Reset = 1'b0;
        model_reset();
        @(negedge PixelClk2);
        check("stray_cleared", 32'(ErrStray), 32'(0));
        check("rdata_cleared", 32'(HostRData), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 22, memory word address width
- DW, 16, data width
- BURST, 16, words per video fetch burst (power of 2, 2..64)
- LBW, 10, line-buffer address width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- PixelClk2, in, 1, single clock for all logic
- Reset, in, 1, synchronous, active-high
- VidReq, in, 1, video line-fetch request (level)
- VidAddr, in, AW, burst start word address
- VidLbAddr, in, LBW, line-buffer start address
- VidAck, out, 1, one-cycle pulse on grant
- VidDone, out, 1, one-cycle pulse on last word written
- LbWe, out, 1, line-buffer write strobe
- LbAddr, out, LBW, line-buffer write address
- LbData, out, DW, line-buffer write data
- HostReq, in, 1, host single-word request (level)
- HostWe, in, 1, 1 = write, 0 = read
- HostAddr, in, AW, host word address
- HostWData, in, DW, host write data
- HostRData, out, DW, host read data
- HostAck, out, 1, one-cycle completion pulse
- MemCmdValid, out, 1, command valid
- MemCmdReady, in, 1, command accepted when Valid&Ready
- MemWe, out, 1, command is a write
- MemAddr, out, AW, command address
- MemWData, out, DW, write data
- MemRValid, in, 1, read data valid, in command order
- MemRData, in, DW, read data
- Busy, out, 1, state != IDLE
- ErrStray, out, 1, sticky: MemRValid seen with no read outstanding
REQ-003 One clock (PixelClk2); reset is synchronous and active-high (Reset).

Function
REQ-010 FSM states SHALL be IDLE, VCMD, VDATA, HCMD, HDATA.
REQ-011 IDLE grant: only VidReq -> video; only HostReq -> host; both -> host if the previous grant was video, else video (alternating); neither -> stay.
REQ-012 Video grant SHALL latch VidAddr and VidLbAddr, zero cmd_cnt and dat_cnt, pulse VidAck in the transition cycle, and enter VCMD.
REQ-013 VCMD: MemCmdValid=1, MemWe=0, MemAddr=(base+cmd_cnt) mod 2^AW; cmd_cnt increments on each Valid&Ready; the BURST-th accept moves to VDATA unless all data has already arrived.
REQ-014 In VCMD and VDATA each MemRValid SHALL set LbWe=1 the same cycle, with LbAddr=(lbbase+dat_cnt) mod 2^LBW and LbData=MemRData (combinational pass-through); dat_cnt then increments.
REQ-015 When dat_cnt reaches BURST, VidDone SHALL pulse in the cycle of the final LbWe, and the FSM returns to IDLE next cycle.
REQ-016 Host grant SHALL latch HostWe, HostAddr and HostWData and enter HCMD; MemCmdValid=1, MemWe=latched We.
REQ-017 HCMD accept: a write pulses HostAck the next cycle and returns to IDLE; a read enters HDATA.
REQ-018 HDATA: on MemRValid, HostRData<=MemRData, HostAck pulses the next cycle, and the FSM returns to IDLE; HostRData holds until the next host read.
REQ-019 MemCmdValid SHALL stay high with stable MemAddr/MemWe/MemWData until Ready; it is never high in IDLE, VDATA or HDATA.
REQ-020 MemRValid in IDLE, HCMD, or in VCMD/VDATA with dat_cnt >= cmd_cnt SHALL set ErrStray and be otherwise ignored.
REQ-021 Requests SHALL be sampled only in IDLE; request changes during service have no effect. Requesters hold their signals until their Ack.
REQ-022 Worst-case video grant latency after VidReq rises: one complete host access plus one cycle.

Reset
REQ-030 Reset SHALL force IDLE, zero all counters, clear the fairness flag (video wins the first tie), and drive VidAck, VidDone, LbWe, HostAck, MemCmdValid, Busy and ErrStray low, with HostRData=0.
REQ-031 Reset mid-burst SHALL abandon the transfer without VidDone; the memory controller is reset in the same cycle.

Verification
REQ-040 VidReq with VidAddr=0x000100, VidLbAddr=0x020, Ready always 1, RValid 2 cycles after each accept -> 16 commands to 0x100..0x10F, LbWe at 0x020..0x02F, one VidDone, ErrStray=0.
REQ-041 VidReq and HostReq both rise together after Reset -> video served first, then the host; next tie -> video (alternation).
REQ-042 Host write 0xBEEF to 0x3FFFFF with Ready delayed 5 cycles -> MemCmdValid stable for 6 cycles, one HostAck, no LbWe.
REQ-043 VidAddr=0x3FFFF8, VidLbAddr=0x3F8 -> MemAddr wraps 0x3FFFFF->0x000000, LbAddr wraps 0x3FF->0x000.
REQ-044 Reset asserted after the 7th video accept -> next cycle IDLE, all strobes low, no VidDone; a subsequent host read completes normally.
REQ-045 MemRValid pulsed while IDLE -> ErrStray=1 and stays 1 until Reset.
